bpsk_demod: RTL and testbench
=============================

Name: bpsk_demod

Overview:
- Receive-side stage placed directly downstream of the BPSK modulator top level.
- Consumes the 8-bit modulated carrier sample stream (the modulator's mux output) and correlates each bit period against a locally generated reference-phase sign.
- Decides each bit and reassembles bytes MSB-first, so the recovered byte can be compared against the modulator's parallel input.
- Sample timing is externally aligned via a start pulse; no carrier or timing recovery.

Parameters:
- SAMPLES_PER_BIT, 16, carrier samples per bit period; even, ≥4.
- SAMPLE_W, 8, sample width; samples are offset-binary, midpoint 2^(SAMPLE_W-1) = 128.
- ACC_W, $clog2(SAMPLES_PER_BIT)+SAMPLE_W+1, signed correlator accumulator width (13 at defaults).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame-alignment pulse; the next accepted sample is phase 0 of bit 7.
- sample_in  in  SAMPLE_W  modulated carrier sample, offset binary.
- sample_valid  in  1  sample_in is accepted this cycle when high.
- bit_out  out  1  last decided bit.
- bit_valid  out  1  one-cycle pulse; bit_out is new.
- data_out  out  8  last complete recovered byte.
- byte_valid  out  1  one-cycle pulse; data_out is new.
- busy  out  1  high while in RUN.
- tie_err  out  1  sticky; set when a bit decision sees accumulator == 0; cleared by start or reset.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, phase counter 0, accumulator 0, shift register 0, bit counter 0.
- States:
  - IDLE: samples are ignored. start moves to RUN and clears the phase counter, accumulator, bit counter and tie_err.
  - RUN: each accepted sample (sample_valid=1) is processed as described below.
- Sample processing in RUN:
  - s = sample_in − 128, signed (SAMPLE_W+1) bits.
  - ref = +1 when phase < SAMPLES_PER_BIT/2, else −1.
  - acc_next = acc + ref·s.
  - phase increments and wraps at SAMPLES_PER_BIT−1.
- Bit decision on the accepted sample with phase == SAMPLES_PER_BIT−1:
  - bit = (acc_next > 0); positive correlation means bit 1, i.e. carrier in reference phase.
  - acc_next == 0 gives bit 0 and sets tie_err.
  - acc is cleared for the next bit.
  - Next cycle: bit_out = bit and bit_valid = 1 (latency 1 clk after the last sample of the bit).
- Byte assembly:
  - Bits shift MSB-first into an 8-bit register.
  - On the 8th bit, in the same cycle as that bit's bit_valid: data_out = assembled byte, byte_valid = 1, bit counter resets.
  - State stays RUN; the next frame continues seamlessly with no new start needed.
- sample_valid low: nothing advances; accumulator and phase hold; no gaps are inserted.
- start while in RUN: restart alignment; the partial byte and accumulator are discarded, no byte_valid is emitted, and state stays RUN.
- start and sample_valid in the same cycle: that sample is phase 0 of the new frame and is accumulated with a freshly zeroed accumulator.
- Reset mid-operation: immediate return to reset values; any in-flight bit or byte is lost.
- Accumulator: sized so SAMPLES_PER_BIT full-scale samples cannot overflow; no saturation logic is needed.
- Output data: data_out and bit_out hold their value between pulses.

Test Plan:
- Reset and idle:
  - Stimulus: reset low mid-stream, then high with no start; feed 64 samples.
  - Required: all outputs 0, busy=0, no pulses.
- Byte 0x99, ideal square carrier:
  - Stimulus: start, then 128 contiguous samples. Bit 1 = 8×228 followed by 8×28; bit 0 = inverted.
  - Required: accumulator ±1600 per bit; bit_valid pattern 1,0,0,1,1,0,0,1; one byte_valid with data_out=0x99 one clk after sample 128.
- Gapped valid:
  - Stimulus: same 0x99 stream with sample_valid toggling 1,0.
  - Required: identical bit sequence and data_out=0x99; byte_valid one clk after the final sample.
- Back-to-back bytes:
  - Stimulus: 0xA5 then 0x3C streamed with one start only.
  - Required: two byte_valid pulses exactly 128 accepted samples apart, values 0xA5 then 0x3C.
- Restart and same-cycle start:
  - Stimulus: start again after 40 samples, then a 0x0F stream whose first sample coincides with start.
  - Required: no byte_valid for the aborted partial byte; data_out=0x0F.
- Tie:
  - Stimulus: a bit period of constant 128 samples.
  - Required: bit_out=0 and tie_err=1; tie_err stays set until the next start.

Source files
------------

// File: rtl/bpsk_demod_if.sv
// ----------------------------------------------------------------------------
// bpsk_demod_if
//   Bundles the sample stream into the BPSK demodulator and its decision
//   outputs.
//
//   Sample side (driven by the source):
//     start         one-cycle frame-alignment pulse
//     sample_in     modulated carrier sample, offset binary
//     sample_valid  sample_in is accepted in any cycle where this is high
//   Decision side (driven by the demodulator):
//     bit_out       last decided bit (held between pulses)
//     bit_valid     one-cycle pulse, bit_out is new
//     data_out      last complete recovered byte (held between pulses)
//     byte_valid    one-cycle pulse, data_out is new
//     busy          high while the demodulator is running
//     tie_err       sticky zero-correlation flag
//     dbg_state     current FSM state (0 = IDLE, 1 = RUN)
//
//   Handshake: sample_valid is a qualifier only; there is no ready, the
//   demodulator accepts a sample in every cycle where sample_valid is high.
//   bit_valid/byte_valid are single-cycle strobes with no back-pressure.
// ----------------------------------------------------------------------------
interface bpsk_demod_if #(
    parameter int SAMPLE_W = 8
);
    logic                start;
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                bit_out;
    logic                bit_valid;
    logic [7:0]          data_out;
    logic                byte_valid;
    logic                busy;
    logic                tie_err;
    logic                dbg_state;

    modport master (
        output start, sample_in, sample_valid,
        input  bit_out, bit_valid, data_out, byte_valid, busy, tie_err, dbg_state
    );

    modport slave (
        input  start, sample_in, sample_valid,
        output bit_out, bit_valid, data_out, byte_valid, busy, tie_err, dbg_state
    );
endinterface

// File: rtl/bpsk_demod.sv
// ----------------------------------------------------------------------------
// bpsk_demod
//   Coherent BPSK demodulator for an externally aligned sample stream.
//   Each bit period of SAMPLES_PER_BIT samples is correlated against a
//   square reference (+1 for the first half of the period, -1 for the
//   second). A positive correlation decides bit 1. Bits are packed MSB-first
//   into bytes; frames follow each other without needing a new start.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    bpsk_demod_if slave modport (sample stream in, decisions out)
// ----------------------------------------------------------------------------
module bpsk_demod #(
    parameter int SAMPLES_PER_BIT = 16,
    parameter int SAMPLE_W        = 8,
    parameter int ACC_W           = $clog2(SAMPLES_PER_BIT) + SAMPLE_W + 1
) (
    input  logic         clk,
    input  logic         reset,
    bpsk_demod_if.slave  bus
);

    localparam int PH_W = $clog2(SAMPLES_PER_BIT);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLES_PER_BIT - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(SAMPLES_PER_BIT / 2);
    // Offset-binary midpoint, one bit wider than a sample.
    localparam logic [SAMPLE_W:0] MID = {2'b01, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [7:0]              shift_q;
    logic [2:0]              bit_cnt_q;
    logic                    bit_out_q, bit_valid_q;
    logic [7:0]              data_out_q;
    logic                    byte_valid_q;
    logic                    tie_err_q;

    // Datapath signals for the sample being accepted this cycle.
    logic                    take;
    logic [PH_W-1:0]         phase_eff;
    logic signed [ACC_W-1:0] acc_eff;
    logic signed [SAMPLE_W:0] s;
    logic signed [ACC_W-1:0] s_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic                    last;
    logic                    bit_dec;
    logic [7:0]              shift_next;

    // ------------------------------------------------------------------
    // FSM: next state and sample acceptance
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    // A sample arriving with start is phase 0 of the frame.
                    take    = bus.sample_valid;
                end
            end
            RUN: begin
                take = bus.sample_valid;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Correlator arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        // start re-aligns: the coincident sample sees phase 0 and a zero
        // accumulator regardless of what was in flight.
        phase_eff  = bus.start ? '0 : phase_q;
        acc_eff    = bus.start ? '0 : acc_q;
        s          = $signed({1'b0, bus.sample_in} - MID);
        s_ext      = {{(ACC_W-SAMPLE_W-1){s[SAMPLE_W]}}, s};
        acc_next   = (phase_eff < PH_HALF) ? (acc_eff + s_ext) : (acc_eff - s_ext);
        last       = (phase_eff == PH_LAST);
        bit_dec    = (acc_next > 0);
        shift_next = {shift_q[6:0], bit_dec};
    end

    // ------------------------------------------------------------------
    // Accumulator, phase, bit/byte assembly and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q      <= '0;
            acc_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            data_out_q   <= '0;
            byte_valid_q <= 1'b0;
            tie_err_q    <= 1'b0;
        end else begin
            bit_valid_q  <= 1'b0;
            byte_valid_q <= 1'b0;

            // Restart alignment; discards the partial byte and bit.
            // An accepted sample below overrides phase/acc as needed.
            if (bus.start) begin
                phase_q   <= '0;
                acc_q     <= '0;
                shift_q   <= '0;
                bit_cnt_q <= '0;
                tie_err_q <= 1'b0;
            end

            if (take) begin
                if (last) begin
                    // last can never coincide with start (phase_eff is 0 then),
                    // so bit_cnt_q/shift_q here belong to the running frame.
                    phase_q     <= '0;
                    acc_q       <= '0;
                    bit_out_q   <= bit_dec;
                    bit_valid_q <= 1'b1;
                    shift_q     <= shift_next;
                    if (acc_next == 0) begin
                        tie_err_q <= 1'b1;
                    end
                    if (bit_cnt_q == 3'd7) begin
                        data_out_q   <= shift_next;
                        byte_valid_q <= 1'b1;
                        bit_cnt_q    <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end else begin
                    phase_q <= phase_eff + PH_W'(1);
                    acc_q   <= acc_next;
                end
            end
        end
    end

    assign bus.bit_out    = bit_out_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.data_out   = data_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.tie_err    = tie_err_q;
    assign bus.dbg_state  = (state_q == RUN);

endmodule

// File: tb/tb_bpsk_demod.sv
// ----------------------------------------------------------------------------
// tb_bpsk_demod
//   Directed bench for bpsk_demod. Inputs change on the falling edge; a
//   monitor looks at the outputs 1 time unit after each rising edge and logs
//   every bit and byte strobe, together with the number of samples accepted
//   since the last start, so each scenario task can compare the log against
//   hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_bpsk_demod;

    localparam int SPB = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    bpsk_demod_if #(.SAMPLE_W(8)) bus ();

    bpsk_demod #(.SAMPLES_PER_BIT(SPB), .SAMPLE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;

    logic       obs_bits[$];
    logic [7:0] obs_bytes[$];
    int         obs_n[$];
    logic [7:0] exp_q[$];

    // Monitor
    always @(posedge clk) begin
        #1;
        if (bus.bit_valid) obs_bits.push_back(bus.bit_out);
        if (bus.byte_valid) begin
            obs_bytes.push_back(bus.data_out);
            obs_n.push_back(n_acc);
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive(input logic [7:0] v, input logic vld, input logic st);
        @(negedge clk);
        bus.start        = st;
        bus.sample_in    = v;
        bus.sample_valid = vld;
        if (st) n_acc = 0;
        if (vld) n_acc++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0);
    endtask

    // Ideal square carrier: bit 1 = 8 x 228 then 8 x 228's mirror (28).
    task automatic send_bit(input logic b, input logic gap, input logic st_first);
        for (int p = 0; p < SPB; p++) begin
            logic hi;
            hi = ((p < SPB/2) == b);
            drive(hi ? 8'd228 : 8'd28, 1'b1, st_first && (p == 0));
            if (gap) drive(8'h00, 1'b0, 1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic gap, input logic st_first);
        for (int i = 7; i >= 0; i--) send_bit(d[i], gap, st_first && (i == 7));
    endtask

    task automatic clear_obs();
        obs_bits.delete();
        obs_bytes.delete();
        obs_n.delete();
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        // Get something in flight first.
        drive(8'h00, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(8'd228, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.bit_out    !== 1'b0)  begin errors++; $display("FAIL rst_bit_out got=%b exp=0", bus.bit_out); end
        checks++; if (bus.bit_valid  !== 1'b0)  begin errors++; $display("FAIL rst_bit_valid got=%b exp=0", bus.bit_valid); end
        checks++; if (bus.data_out   !== 8'h00) begin errors++; $display("FAIL rst_data_out got=%h exp=00", bus.data_out); end
        checks++; if (bus.byte_valid !== 1'b0)  begin errors++; $display("FAIL rst_byte_valid got=%b exp=0", bus.byte_valid); end
        checks++; if (bus.busy       !== 1'b0)  begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.tie_err    !== 1'b0)  begin errors++; $display("FAIL rst_tie_err got=%b exp=0", bus.tie_err); end
        idle(2);
        reset = 1'b1;
        clear_obs();
        // No start: 64 samples must be ignored.
        for (int i = 0; i < 64; i++) drive((i % 16) < 8 ? 8'd228 : 8'd28, 1'b1, 1'b0);
        idle(3);
        checks++; if (obs_bits.size()  != 0)   begin errors++; $display("FAIL idle_bit_pulses got=%0d exp=0", obs_bits.size()); end
        checks++; if (obs_bytes.size() != 0)   begin errors++; $display("FAIL idle_byte_pulses got=%0d exp=0", obs_bytes.size()); end
        checks++; if (bus.busy     !== 1'b0)   begin errors++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.data_out !== 8'h00)  begin errors++; $display("FAIL idle_data_out got=%h exp=00", bus.data_out); end
        checks++; if (bus.bit_out  !== 1'b0)   begin errors++; $display("FAIL idle_bit_out got=%b exp=0", bus.bit_out); end
        checks++; if (bus.tie_err  !== 1'b0)   begin errors++; $display("FAIL idle_tie_err got=%b exp=0", bus.tie_err); end
    endtask

    task automatic test_byte(input logic [7:0] d, input logic gap, input string name);
        clear_obs();
        drive(8'h00, 1'b0, 1'b1);
        send_byte(d, gap, 1'b0);
        idle(3);
        checks++; if (obs_bits.size() != 8) begin errors++; $display("FAIL %s_bit_count got=%0d exp=8", name, obs_bits.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < obs_bits.size()) begin
                checks++;
                if (obs_bits[i] !== d[7-i]) begin
                    errors++; $display("FAIL %s_bit%0d got=%b exp=%b", name, i, obs_bits[i], d[7-i]);
                end
            end
        end
        checks++; if (obs_bytes.size() != 1) begin errors++; $display("FAIL %s_byte_count got=%0d exp=1", name, obs_bytes.size()); end
        if (obs_bytes.size() >= 1) begin
            checks++; if (obs_bytes[0] !== d) begin errors++; $display("FAIL %s_byte got=%h exp=%h", name, obs_bytes[0], d); end
            checks++; if (obs_n[0] != 128)    begin errors++; $display("FAIL %s_byte_latency got=%0d exp=128", name, obs_n[0]); end
        end
        checks++; if (bus.data_out !== d)    begin errors++; $display("FAIL %s_data_hold got=%h exp=%h", name, bus.data_out, d); end
        checks++; if (bus.bit_out  !== d[0]) begin errors++; $display("FAIL %s_bit_hold got=%b exp=%b", name, bus.bit_out, d[0]); end
        checks++; if (bus.busy     !== 1'b1) begin errors++; $display("FAIL %s_busy got=%b exp=1", name, bus.busy); end
        checks++; if (bus.tie_err  !== 1'b0) begin errors++; $display("FAIL %s_tie_err got=%b exp=0", name, bus.tie_err); end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        drive(8'h00, 1'b0, 1'b1);
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        idle(3);
        checks++; if (obs_bytes.size() != 2) begin errors++; $display("FAIL b2b_byte_count got=%0d exp=2", obs_bytes.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < obs_bytes.size()) begin
                checks++;
                if (obs_bytes[i] !== exp_q[i]) begin
                    errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, obs_bytes[i], exp_q[i]);
                end
            end
        end
        if (obs_n.size() == 2) begin
            checks++; if (obs_n[1] - obs_n[0] != 128) begin errors++; $display("FAIL b2b_spacing got=%0d exp=128", obs_n[1] - obs_n[0]); end
        end
    endtask

    task automatic test_restart();
        logic exp_bits[$];
        clear_obs();
        exp_bits = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        drive(8'h00, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(8'd228, 1'b1, 1'b0);
        // 40 samples in; restart on the first sample of the new byte.
        send_byte(8'h0F, 1'b0, 1'b1);
        idle(3);
        checks++; if (obs_bits.size() != 10) begin errors++; $display("FAIL rs_bit_count got=%0d exp=10", obs_bits.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < obs_bits.size()) begin
                checks++;
                if (obs_bits[i] !== exp_bits[i]) begin
                    errors++; $display("FAIL rs_bit%0d got=%b exp=%b", i, obs_bits[i], exp_bits[i]);
                end
            end
        end
        checks++; if (obs_bytes.size() != 1) begin errors++; $display("FAIL rs_byte_count got=%0d exp=1", obs_bytes.size()); end
        if (obs_bytes.size() >= 1) begin
            checks++; if (obs_bytes[0] !== 8'h0F) begin errors++; $display("FAIL rs_byte got=%h exp=0f", obs_bytes[0]); end
            checks++; if (obs_n[0] != 128)        begin errors++; $display("FAIL rs_byte_latency got=%0d exp=128", obs_n[0]); end
        end
    endtask

    task automatic test_tie();
        clear_obs();
        drive(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < SPB; i++) drive(8'd128, 1'b1, 1'b0);
        idle(2);
        checks++; if (obs_bits.size() != 1) begin errors++; $display("FAIL tie_bit_count got=%0d exp=1", obs_bits.size()); end
        checks++; if (bus.bit_out !== 1'b0) begin errors++; $display("FAIL tie_bit_out got=%b exp=0", bus.bit_out); end
        checks++; if (bus.tie_err !== 1'b1) begin errors++; $display("FAIL tie_set got=%b exp=1", bus.tie_err); end
        // Seven clean 1 bits complete the byte 0x7F; the flag must persist.
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0, 1'b0);
        idle(2);
        checks++; if (bus.tie_err !== 1'b1) begin errors++; $display("FAIL tie_sticky got=%b exp=1", bus.tie_err); end
        checks++; if (obs_bytes.size() != 1) begin errors++; $display("FAIL tie_byte_count got=%0d exp=1", obs_bytes.size()); end
        if (obs_bytes.size() >= 1) begin
            checks++; if (obs_bytes[0] !== 8'h7F) begin errors++; $display("FAIL tie_byte got=%h exp=7f", obs_bytes[0]); end
        end
        drive(8'h00, 1'b0, 1'b1);
        idle(2);
        checks++; if (bus.tie_err !== 1'b0) begin errors++; $display("FAIL tie_clear got=%b exp=0", bus.tie_err); end
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        bus.start        = 1'b0;
        bus.sample_in    = 8'h00;
        bus.sample_valid = 1'b0;
        reset            = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        test_reset();
        test_byte(8'h99, 1'b0, "b99");
        test_byte(8'h99, 1'b1, "gap");
        test_back_to_back();
        test_restart();
        test_tie();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
